pipelined_instr_decoder: RTL and testbench

- Registered, parameterised successor to the combinational instruction decoder.
- Accepts one instruction per cycle over a valid/ready handshake and decodes ALU, jump, conditional-jump, store and load formats.
- Flags illegal encodings and presents decoded fields on a registered valid/ready output with a 2-entry skid buffer.
- Sits between instruction fetch and register-file/ALU issue; a flush input squashes in-flight instructions after a taken jump.

---
 rtl/pipelined_instr_decoder.sv | 154 +++++++++++++++
 tb/tb_pipelined_instr_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_instr_decoder.sv
// Registered instruction decoder: valid/ready input, 1-cycle latency, main + skid output stage.
// Optional macro DECODER_STATS_EN adds handshake and illegal-instruction counters.
module pipelined_instr_decoder #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int ADDR_W  = 8,
    parameter int OP_W    = 4,
    parameter int SHOW_OP = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] in1,
    output logic [REG_AW-1:0] in2,
    output logic [OP_W-1:0]   aluop,
    output logic [ADDR_W-1:0] data_addr,
    output logic              show,
    output logic              write,
    output logic              is_jump,
    output logic              is_jumpz,
    output logic              is_load,
    output logic              illegal
`ifdef DECODER_STATS_EN
    ,
    output logic [15:0]       instr_count,
    output logic [15:0]       illegal_count
`endif
);

    typedef struct packed {
        logic [REG_AW-1:0] in1;
        logic [REG_AW-1:0] in2;
        logic [OP_W-1:0]   aluop;
        logic [ADDR_W-1:0] data_addr;
        logic              show;
        logic              write;
        logic              is_jump;
        logic              is_jumpz;
        logic              is_load;
        logic              illegal;
    } dec_t;

    function automatic logic [INSTR_W-1:0] range_mask(input int lo, input int hi);
        logic [INSTR_W-1:0] m;
        m = '0;
        for (int i = 0; i < INSTR_W; i++) m[i] = (i >= lo) && (i <= hi);
        return m;
    endfunction

    // Reserved-bit masks may be empty when the instruction has no spare bits.
    localparam logic [INSTR_W-1:0] ALU_RSV = range_mask(2*REG_AW+OP_W, INSTR_W-2);
    localparam logic [INSTR_W-1:0] MEM_RSV = range_mask(ADDR_W+REG_AW, INSTR_W-4);

    function automatic dec_t decode(input logic [INSTR_W-1:0] w);
        dec_t d;
        d = '0;
        if (!w[INSTR_W-1]) begin
            d.in2     = w[REG_AW-1:0];
            d.in1     = w[2*REG_AW-1:REG_AW];
            d.aluop   = w[2*REG_AW+OP_W-1:2*REG_AW];
            d.illegal = |(w & ALU_RSV);
            d.show    = !d.illegal && (d.aluop == OP_W'(SHOW_OP));
        end else begin
            d.data_addr = w[ADDR_W-1:0];
            d.illegal   = |(w & MEM_RSV);
            case (w[INSTR_W-2:INSTR_W-3])
                2'b00: d.is_jump = !d.illegal;
                2'b01: begin d.in1 = w[ADDR_W+REG_AW-1:ADDR_W]; d.is_jumpz = !d.illegal; end
                2'b10: begin d.in1 = w[ADDR_W+REG_AW-1:ADDR_W]; d.write    = !d.illegal; end
                default: begin d.in1 = w[ADDR_W+REG_AW-1:ADDR_W]; d.is_load = !d.illegal; end
            endcase
        end
        return d;
    endfunction

    // Handshake: a transfer happens on an edge where valid && ready; valid is never
    // withdrawn by the decoder while out_ready=0, and in_ready depends only on state.
    dec_t main_q, main_n, skid_q, skid_n;
    logic main_valid, main_valid_n, skid_valid, skid_valid_n, ready_q;
    logic accept;

    assign accept = in_valid && ready_q;

    always_comb begin
        main_valid_n = main_valid;
        main_n       = main_q;
        skid_valid_n = skid_valid;
        skid_n       = skid_q;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_n       = skid_q;
                skid_valid_n = 1'b0;
            end else begin
                main_valid_n = accept;
                if (accept) main_n = decode(instr);
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_n       = decode(instr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            ready_q    <= !skid_valid_n;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign in1       = main_q.in1;
    assign in2       = main_q.in2;
    assign aluop     = main_q.aluop;
    assign data_addr = main_q.data_addr;
    assign show      = main_q.show;
    assign write     = main_q.write;
    assign is_jump   = main_q.is_jump;
    assign is_jumpz  = main_q.is_jumpz;
    assign is_load   = main_q.is_load;
    assign illegal   = main_q.illegal;

`ifdef DECODER_STATS_EN
    // A flush suppresses the output handshake, so flushed entries are never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count   <= '0;
            illegal_count <= '0;
        end else if (!flush && main_valid && out_ready) begin
            instr_count <= instr_count + 16'd1;
            if (main_q.illegal) illegal_count <= illegal_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Bench for pipelined_instr_decoder: directed scenarios plus random traffic against a queue model.
module tb_pipelined_instr_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  in1, in2;
    logic [3:0]  aluop;
    logic [7:0]  data_addr;
    logic        show, write, is_jump, is_jumpz, is_load, illegal;
`ifdef DECODER_STATS_EN
    logic [15:0] instr_count, illegal_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];
    int n_hs  = 0;
    int n_ill = 0;

    pipelined_instr_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .in1(in1), .in2(in2), .aluop(aluop), .data_addr(data_addr),
        .show(show), .write(write), .is_jump(is_jump), .is_jumpz(is_jumpz),
        .is_load(is_load), .illegal(illegal)
`ifdef DECODER_STATS_EN
        , .instr_count(instr_count), .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference decode from the field layout, using integer division for bit extraction.
    function automatic logic [23:0] ref_dec(input logic [15:0] w);
        int u, i1, i2, op, addr, sub, bad_bits;
        logic sh, wr, j, jz, ld, il;
        u = int'(w);
        i1 = 0; i2 = 0; op = 0; addr = 0;
        sh = 0; wr = 0; j = 0; jz = 0; ld = 0;
        if (u < 32768) begin
            i2 = u % 8; i1 = (u / 8) % 8; op = (u / 64) % 16;
            bad_bits = (u / 1024) % 32;
            il = (bad_bits != 0);
            sh = !il && (op == 5);
        end else begin
            addr = u % 256; sub = (u / 8192) % 4;
            bad_bits = (u / 2048) % 4;
            il = (bad_bits != 0);
            i1 = (sub == 0) ? 0 : (u / 256) % 8;
            j = !il && sub == 0; jz = !il && sub == 1;
            wr = !il && sub == 2; ld = !il && sub == 3;
        end
        return {3'(i1), 3'(i2), 4'(op), 8'(addr), sh, wr, j, jz, ld, il};
    endfunction

    function automatic logic [23:0] dut_word();
        return {in1, in2, aluop, data_addr, show, write, is_jump, is_jumpz, is_load, illegal};
    endfunction

    // One clock cycle: drive, check against the model before the edge, update the model.
    task automatic step(input logic v, input logic [15:0] w, input logic ordy, input logic fl);
        logic hs_out, hs_in;
        in_valid = v; instr = w; out_ready = ordy; flush = fl;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        if (out_valid && exp_q.size() > 0) check("fields", 32'(dut_word()), 32'(exp_q[0]));
        hs_out = out_valid && ordy;
        hs_in  = v && in_ready;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (hs_out && exp_q.size() > 0) begin
                n_hs++;
                if (exp_q[0][0]) n_ill++;
                void'(exp_q.pop_front());
            end
            if (hs_in) exp_q.push_back(ref_dec(w));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_fields", 32'(dut_word()), 32'd0);
        exp_q.delete();
        n_hs = 0; n_ill = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        do_reset();

        // ALU with show opcode
        step(1, 16'h0153, 1, 0);
        check("alu_word", 32'(dut_word()), {8'h0, 3'd2, 3'd3, 4'd5, 8'h00, 6'b100000});
        step(0, 16'h0, 1, 0);

        // Memory/branch formats back-to-back
        step(1, 16'h8042, 1, 0);
        check("jump", 32'({is_jump, data_addr}), 32'h142);
        step(1, 16'hA3FF, 1, 0);
        check("jumpz", 32'({is_jumpz, in1, data_addr}), 32'h3FF | 32'h800);
        step(1, 16'hC5AA, 1, 0);
        check("store", 32'({write, in1, data_addr}), 32'h5AA | 32'h800);
        step(1, 16'hE10F, 1, 0);
        check("load", 32'({is_load, in1, data_addr}), 32'h10F | 32'h800);
        step(0, 16'h0, 1, 0);

        // Stall: third offer is refused, output holds first entry
        step(1, 16'h0153, 0, 0);
        step(1, 16'h8042, 0, 0);
        step(1, 16'hC5AA, 0, 0);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_hold_show", 32'(show), 32'd1);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        check("drained_in_ready", 32'(in_ready), 32'd1);

        // Illegal encodings
        step(1, 16'h0840, 1, 0);
        check("ill_alu", 32'({illegal, show, write, is_jump, is_jumpz, is_load}), 32'h20);
        step(1, 16'h9800, 1, 0);
        check("ill_mem", 32'({illegal, show, write, is_jump, is_jumpz, is_load}), 32'h20);
        step(0, 16'h0, 1, 0);

        // Flush with two held and one offered
        step(1, 16'h0153, 0, 0);
        step(1, 16'hA3FF, 0, 0);
        step(1, 16'hE10F, 1, 1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        step(0, 16'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w = w[15] ? (w & 16'hE7FF) : (w & 16'h83FF);
            step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
`ifdef DECODER_STATS_EN
            check("instr_count", 32'(instr_count), 32'(16'(n_hs)));
            check("illegal_count", 32'(illegal_count), 32'(16'(n_ill)));
`endif
            if (i == 300) do_reset();
        end

        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0);
        check("final_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
